aig_tt_extractor: RTL and testbench
===================================

Name: aig_tt_extractor

Overview:
Sequential harness that reads the truth table of a 4-input, single-output combinational AIG cone. It is the reader for the exact-synthesis netlists: those netlists map x0..x3 to y0, and this block drives all 16 minterms into such a cone, samples y0, and assembles the 16-bit truth table. It also compares the table against an expected table, so synthesized netlists can be checked for NPN-class equivalence on silicon or in emulation.

Parameters:
NUM_IN, 4, number of cone inputs (fixed at 4 for this block; kept only for the package)
TT_W, 16, truth-table width, equal to 2**NUM_IN
SETTLE, 1, cycles from a stim_x change to the dut_y sample edge; must be at least 1; 0 is illegal and is caught by an elaboration assertion

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
start_valid  input  1  request to start a scan
start_ready  output  1  high only in IDLE
expect_tt  input  16  expected table; latched on start handshake
stim_x  output  4  registered minterm index to the cone; bit0=x0, bit3=x3
dut_y  input  1  cone output y0
tt  output  16  captured table; bit m = y0 at minterm m
mismatch  output  16  tt XOR latched expect_tt
match  output  1  high when mismatch == 0; meaningful only while tt_valid
tt_valid  output  1  result valid
tt_ready  input  1  result consumer ready

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE.
  - stim_x=0, tt=0, mismatch=0, match=0, tt_valid=0.
  - start_ready=1 from the first cycle after reset.
  - Reset mid-scan or in DONE aborts immediately; the partial table is discarded.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start_ready=1.
  - On an edge with start_valid=1: latch expect_tt, set stim_x=0, load the settle counter with SETTLE-1, clear tt, go to SCAN.
- SCAN:
  - start_ready=0.
  - Each minterm m holds stim_x=m for exactly SETTLE cycles.
  - The sample edge is the edge at which the settle counter reads 0. At that edge, tt[m] <= dut_y.
  - At a sample edge with m<15: stim_x <= m+1 and the counter reloads to SETTLE-1.
  - At a sample edge with m=15: stim_x stays 15, the state goes to DONE, and tt_valid <= 1. At the same edge, mismatch and match are registered from the final tt, including bit 15.
  - Latency: tt_valid rises exactly 16*SETTLE edges after the start-accept edge.
  - start_valid is ignored during SCAN.
- DONE:
  - tt, mismatch, match and tt_valid are held stable until an edge with tt_ready=1.
  - At that edge: tt_valid <= 0, state goes to IDLE, stim_x <= 0.
  - tt and mismatch keep their values until the next start.
  - start_valid in the same cycle as tt_ready is not accepted; the earliest new accept is the following edge, so the minimum period is 16*SETTLE+2 cycles.
- stim_x wrap: the index never wraps inside a scan; a 5-bit internal index is not permitted, the 4-bit index plus the state encodes completion.
- Settle counter width: clog2(SETTLE) bits, minimum 1.
- tt_ready outside DONE is ignored.

Decomposition:
- Package aig_tt_pkg holds:
  - NUM_IN and TT_W localparams.
  - The state enum (IDLE, SCAN, DONE).
  - Function tt_of_var(i) returning the projection tables 0xAAAA, 0xCCCC, 0xF0F0, 0xFF00.
- One sub-module, aig_settle_timer: a down-counter with a load and a zero flag, parameterised by SETTLE.

Test Plan:
1. Cone y0=x0, SETTLE=1, expect_tt=0xAAAA, start pulse:
   - stim_x steps 0..15 on consecutive cycles.
   - tt_valid rises 16 cycles after accept with tt=0xAAAA, mismatch=0, match=1.
2. Cone y0=x0&x1&x2&x3, SETTLE=3, expect_tt=0x8000:
   - Each stim_x value is held 3 cycles.
   - tt_valid rises at 48 cycles with tt=0x8000 and match=1.
3. Cone y0=x3, expect_tt=0xFF01:
   - tt=0xFF00, mismatch=0x0001, match=0.
   - With tt_ready held low for 10 cycles, all outputs stay stable; tt_ready=1 returns to IDLE next edge with start_ready=1.
4. Reset mid-scan: rst_n=0 for 1 cycle while stim_x=7:
   - Next cycle state=IDLE, stim_x=0, tt=0, tt_valid=0.
   - A fresh scan of cone y0=~x1 gives 0x3333.
5. start_valid held high continuously with tt_ready=1 and cone y0=0:
   - Scans repeat with a period of 18 cycles (SETTLE=1), each with tt=0x0000.
   - No start is accepted during SCAN or DONE.
6. Reference cone with the NPN function y0 = ~((x0|x2)&~(x0&~x3)) & (x1 ^ (~x2&(x0|x3))), expect_tt from the golden model:
   - match=1.
   - Flipping bit 5 of expect_tt gives mismatch=0x0020.

Source files
------------

// File: rtl/aig_tt_pkg.sv
// Shared definitions for the 4-input AIG truth-table reader.
package aig_tt_pkg;

  localparam int NUM_IN = 4;
  localparam int TT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Truth table of the projection y = x_i over all 16 minterms.
  function automatic logic [TT_W-1:0] tt_of_var(input int unsigned i);
    logic [TT_W-1:0] r;
    case (i)
      0:       r = 16'hAAAA;
      1:       r = 16'hCCCC;
      2:       r = 16'hF0F0;
      3:       r = 16'hFF00;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aig_settle_timer.sv
// Down-counter that paces each minterm: load reloads SETTLE-1, zero flags the sample cycle.
module aig_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

  logic [CW-1:0] count;

  // Load wins over decrement; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/aig_tt_extractor.sv
// Drives all 16 minterms into a 4-input cone, assembles its truth table and
// compares it with an expected table latched at start.
module aig_tt_extractor
  import aig_tt_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [TT_W-1:0]   expect_tt,
  output logic [NUM_IN-1:0] stim_x,
  input  logic              dut_y,
  output logic [TT_W-1:0]   tt,
  output logic [TT_W-1:0]   mismatch,
  output logic              match,
  output logic              tt_valid,
  input  logic              tt_ready
);

  if (SETTLE < 1) begin : g_bad_settle
    $error("aig_tt_extractor: SETTLE must be at least 1");
  end

  state_t          state, state_next;
  logic [TT_W-1:0] exp_tt;
  logic [TT_W-1:0] tt_sampled;
  logic            zero, load, dec, accept, sample, release_res;

  aig_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .dec   (dec),
    .zero  (zero)
  );

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    dec         = 1'b0;
    accept      = 1'b0;
    sample      = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        if (start_valid) begin
          accept     = 1'b1;
          load       = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (zero) begin
          sample = 1'b1;
          if (stim_x == 4'hF) state_next = DONE;
          else                load       = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      DONE: begin
        if (tt_ready) begin
          release_res = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Table including the bit captured at this edge, so the final compare sees bit 15.
  always_comb begin
    tt_sampled         = tt;
    tt_sampled[stim_x] = dut_y;
  end

  assign start_ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Minterm index, capture and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stim_x   <= '0;
      tt       <= '0;
      mismatch <= '0;
      match    <= 1'b0;
      tt_valid <= 1'b0;
    end else begin
      if (accept) begin
        exp_tt <= expect_tt;
        stim_x <= '0;
        tt     <= '0;
      end
      if (sample) begin
        tt <= tt_sampled;
        if (stim_x != 4'hF) begin
          stim_x <= stim_x + 4'd1;
        end else begin
          tt_valid <= 1'b1;
          mismatch <= tt_sampled ^ exp_tt;
          match    <= (tt_sampled == exp_tt);
        end
      end
      if (release_res) begin
        tt_valid <= 1'b0;
        stim_x   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aig_tt_extractor.sv
// Self-checking bench: two readers (SETTLE=1 and SETTLE=3) driving behavioural cones.
module tb_aig_tt_extractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic        start_valid1 = 1'b0, start_ready1, tt_valid1, match1, tt_ready1 = 1'b0;
  logic [15:0] expect1 = '0, tt1, mm1, cone1 = '0;
  logic [3:0]  stim_x1;
  logic        y1;
  // SETTLE=3 instance
  logic        start_valid3 = 1'b0, start_ready3, tt_valid3, match3, tt_ready3 = 1'b0;
  logic [15:0] expect3 = '0, tt3, mm3, cone3 = '0;
  logic [3:0]  stim_x3;
  logic        y3;

  // The cone: combinational lookup of its own function at the presented minterm.
  assign y1 = cone1[stim_x1];
  assign y3 = cone3[stim_x3];

  aig_tt_extractor #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid1), .start_ready(start_ready1),
    .expect_tt(expect1), .stim_x(stim_x1), .dut_y(y1), .tt(tt1), .mismatch(mm1),
    .match(match1), .tt_valid(tt_valid1), .tt_ready(tt_ready1));

  aig_tt_extractor #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid3), .start_ready(start_ready3),
    .expect_tt(expect3), .stim_x(stim_x3), .dut_y(y3), .tt(tt3), .mismatch(mm3),
    .match(match3), .tt_valid(tt_valid3), .tt_ready(tt_ready3));

  int n_checks = 0;
  int n_fail   = 0;

  // Cone library, defined minterm by minterm from the boolean expression.
  function automatic logic [15:0] build_cone(input int sel);
    logic [15:0] r;
    logic x0, x1, x2, x3;
    r = '0;
    for (int m = 0; m < 16; m++) begin
      x0 = m[0]; x1 = m[1]; x2 = m[2]; x3 = m[3];
      case (sel)
        0: r[m] = x0;
        1: r[m] = x0 & x1 & x2 & x3;
        2: r[m] = x3;
        3: r[m] = ~x1;
        4: r[m] = 1'b0;
        default: r[m] = ~((x0 | x2) & ~(x0 & ~x3)) & (x1 ^ (~x2 & (x0 | x3)));
      endcase
    end
    return r;
  endfunction

  // Stimulus helpers (no checking inside): start pulse and result release on instance 1.
  task automatic start1(input logic [15:0] e);
    expect1 = e; start_valid1 = 1'b1;
    @(negedge clk);
    start_valid1 = 1'b0;
  endtask

  task automatic release1();
    tt_ready1 = 1'b1;
    @(negedge clk);
    tt_ready1 = 1'b0;
  endtask

  // Waits for tt_valid1, returns edges since accept (-1 on timeout) and stim_x step errors.
  task automatic wait_valid1(output int lat, output int stim_bad);
    int c;
    c = 0; stim_bad = 0;
    while (tt_valid1 !== 1'b1 && c < 100) begin
      if (stim_x1 !== ((c > 15) ? 4'd15 : 4'(c))) stim_bad++;
      @(negedge clk); c++;
    end
    lat = (tt_valid1 === 1'b1) ? c : -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({start_ready1, stim_x1, tt1, mm1, match1, tt_valid1} !== {1'b1, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state1: got sr=%b x=%h tt=%h mm=%h m=%b v=%b, want sr=1 x=0 tt=0 mm=0 m=0 v=0",
               start_ready1, stim_x1, tt1, mm1, match1, tt_valid1);
    end
    n_checks++;
    if ({start_ready3, stim_x3, tt3, tt_valid3} !== {1'b1, 4'd0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state3: got sr=%b x=%h tt=%h v=%b, want sr=1 x=0 tt=0 v=0",
               start_ready3, stim_x3, tt3, tt_valid3);
    end
  endtask

  task automatic test_identity();
    int lat, bad;
    cone1 = build_cone(0);
    start1(16'hAAAA);
    n_checks++;
    if (start_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL id_busy: start_ready=%b want 0", start_ready1);
    end
    wait_valid1(lat, bad);
    n_checks++;
    if (lat != 16 || bad != 0) begin
      n_fail++; $display("FAIL id_latency: latency=%0d step_errors=%0d want 16/0", lat, bad);
    end
    n_checks++;
    if ({tt1, mm1, match1} !== {16'hAAAA, 16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL id_result: tt=%h mm=%h match=%b want AAAA 0000 1", tt1, mm1, match1);
    end
    release1();
  endtask

  task automatic test_settle3();
    int c, bad;
    cone3 = build_cone(1);
    expect3 = 16'h8000; start_valid3 = 1'b1;
    @(negedge clk);
    start_valid3 = 1'b0;
    c = 0; bad = 0;
    while (tt_valid3 !== 1'b1 && c < 200) begin
      if (stim_x3 !== ((c / 3 > 15) ? 4'd15 : 4'(c / 3))) bad++;
      @(negedge clk); c++;
    end
    n_checks++;
    if (tt_valid3 !== 1'b1 || c != 48 || bad != 0) begin
      n_fail++; $display("FAIL s3_latency: latency=%0d step_errors=%0d valid=%b want 48/0/1", c, bad, tt_valid3);
    end
    n_checks++;
    if ({tt3, mm3, match3} !== {16'h8000, 16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL s3_result: tt=%h mm=%h match=%b want 8000 0000 1", tt3, mm3, match3);
    end
    tt_ready3 = 1'b1;
    @(negedge clk);
    tt_ready3 = 1'b0;
    n_checks++;
    if ({tt_valid3, start_ready3, stim_x3} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL s3_release: v=%b sr=%b x=%h want 0 1 0", tt_valid3, start_ready3, stim_x3);
    end
  endtask

  task automatic test_mismatch_hold();
    int lat, bad, unstable;
    cone1 = build_cone(2);
    start1(16'hFF01);
    wait_valid1(lat, bad);
    n_checks++;
    if (lat != 16 || {tt1, mm1, match1} !== {16'hFF00, 16'h0001, 1'b0}) begin
      n_fail++; $display("FAIL mm_result: lat=%0d tt=%h mm=%h match=%b want 16 FF00 0001 0", lat, tt1, mm1, match1);
    end
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      start_valid1 = 1'b1;
      @(negedge clk);
      if ({tt_valid1, tt1, mm1, match1, start_ready1, stim_x1} !== {1'b1, 16'hFF00, 16'h0001, 1'b0, 1'b0, 4'hF})
        unstable++;
    end
    start_valid1 = 1'b0;
    n_checks++;
    if (unstable != 0) begin
      n_fail++; $display("FAIL mm_hold: unstable_cycles=%0d want 0", unstable);
    end
    release1();
    n_checks++;
    if ({tt_valid1, start_ready1, stim_x1, tt1, mm1} !== {1'b0, 1'b1, 4'd0, 16'hFF00, 16'h0001}) begin
      n_fail++; $display("FAIL mm_release: v=%b sr=%b x=%h tt=%h mm=%h want 0 1 0 FF00 0001",
                         tt_valid1, start_ready1, stim_x1, tt1, mm1);
    end
  endtask

  task automatic test_reset_midscan();
    int c, lat, bad;
    cone1 = build_cone(0);
    start1(16'hAAAA);
    c = 0;
    while (stim_x1 !== 4'd7 && c < 40) begin @(negedge clk); c++; end
    n_checks++;
    if (stim_x1 !== 4'd7) begin
      n_fail++; $display("FAIL rst_reach7: stim_x=%h want 7", stim_x1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({start_ready1, stim_x1, tt1, tt_valid1} !== {1'b1, 4'd0, 16'd0, 1'b0}) begin
      n_fail++; $display("FAIL rst_abort: sr=%b x=%h tt=%h v=%b want 1 0 0000 0", start_ready1, stim_x1, tt1, tt_valid1);
    end
    cone1 = build_cone(3);
    start1(16'h3333);
    wait_valid1(lat, bad);
    n_checks++;
    if (lat != 16 || {tt1, mm1, match1} !== {16'h3333, 16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL rst_rescan: lat=%0d tt=%h mm=%h match=%b want 16 3333 0000 1", lat, tt1, mm1, match1);
    end
    release1();
  endtask

  task automatic test_back_to_back();
    int rises[$];
    int idle_cycles, bad_res;
    logic prev_v;
    cone1 = build_cone(4);
    expect1 = 16'h0000;
    start_valid1 = 1'b1; tt_ready1 = 1'b1;
    idle_cycles = 0; bad_res = 0; prev_v = tt_valid1;
    for (int c = 0; c < 72; c++) begin
      if (start_ready1 === 1'b1) idle_cycles++;
      if (tt_valid1 === 1'b1 && prev_v !== 1'b1) begin
        rises.push_back(c);
        if ({tt1, match1} !== {16'h0000, 1'b1}) bad_res++;
      end
      prev_v = tt_valid1;
      @(negedge clk);
    end
    start_valid1 = 1'b0; tt_ready1 = 1'b0;
    n_checks++;
    if (rises.size() != 4 || idle_cycles != 4) begin
      n_fail++; $display("FAIL b2b_count: scans=%0d idle_cycles=%0d want 4/4", rises.size(), idle_cycles);
    end
    for (int i = 1; i < rises.size(); i++) begin
      n_checks++;
      if (rises[i] - rises[i-1] != 18) begin
        n_fail++; $display("FAIL b2b_period: period=%0d want 18", rises[i] - rises[i-1]);
      end
    end
    n_checks++;
    if (bad_res != 0) begin
      n_fail++; $display("FAIL b2b_result: bad_results=%0d want 0", bad_res);
    end
    @(negedge clk);
  endtask

  task automatic test_npn();
    int lat, bad;
    logic [15:0] golden;
    golden = build_cone(5);
    cone1 = golden;
    start1(golden);
    wait_valid1(lat, bad);
    n_checks++;
    if (lat != 16 || {tt1, mm1, match1} !== {golden, 16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL npn_match: lat=%0d tt=%h mm=%h match=%b want 16 %h 0000 1", lat, tt1, mm1, match1, golden);
    end
    release1();
    start1(golden ^ 16'h0020);
    wait_valid1(lat, bad);
    n_checks++;
    if ({tt1, mm1, match1} !== {golden, 16'h0020, 1'b0}) begin
      n_fail++; $display("FAIL npn_flip5: tt=%h mm=%h match=%b want %h 0020 0", tt1, mm1, match1, golden);
    end
    release1();
  endtask

  task automatic test_random();
    int lat, bad, hold_bad;
    logic [15:0] cone_r, exp_r;
    for (int it = 0; it < 8; it++) begin
      cone_r = 16'($urandom);
      exp_r  = (it % 2 == 0) ? cone_r : (cone_r ^ 16'($urandom));
      cone1  = cone_r;
      start1(exp_r);
      wait_valid1(lat, bad);
      n_checks++;
      if (lat != 16 || bad != 0 || tt1 !== cone_r || mm1 !== (cone_r ^ exp_r) || match1 !== (cone_r == exp_r)) begin
        n_fail++; $display("FAIL rand_scan%0d: lat=%0d tt=%h mm=%h match=%b want 16 %h %h %b",
                           it, lat, tt1, mm1, match1, cone_r, cone_r ^ exp_r, cone_r == exp_r);
      end
      hold_bad = 0;
      repeat ($urandom_range(0, 4)) begin
        @(negedge clk);
        if (tt_valid1 !== 1'b1 || tt1 !== cone_r) hold_bad++;
      end
      release1();
      n_checks++;
      if (hold_bad != 0 || tt_valid1 !== 1'b0 || start_ready1 !== 1'b1) begin
        n_fail++; $display("FAIL rand_release%0d: hold_errors=%0d v=%b sr=%b want 0 0 1", it, hold_bad, tt_valid1, start_ready1);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_identity();
    test_settle3();
    test_mismatch_hold();
    test_reset_midscan();
    test_back_to_back();
    test_npn();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
